// File: rtl/seq_alu_if.sv
// Request/result handshake bundle between an operand-issuing controller and seq_alu.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut;
  logic             Zero;
  logic             Overflow;
  logic             busy;

  modport master (
    output in_valid, A, B, ALU_Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, CarryOut, Zero, Overflow, busy
  );

  modport slave (
    input  in_valid, A, B, ALU_Sel, out_ready,
    output in_ready, out_valid, ALU_Out, CarryOut, Zero, Overflow, busy
  );
endinterface

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle ops, persistent carry for ADC,
// iterative shift-add multiply, single-entry result register with flags.
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  seq_alu_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_ROL  = 4'd8;
  localparam logic [3:0] OP_ROR  = 4'd9;
  localparam logic [3:0] OP_SLT  = 4'd10;
  localparam logic [3:0] OP_SLTU = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_ADC  = 4'd13;
  localparam logic [3:0] OP_PASS = 4'd14;
  localparam logic [3:0] OP_RSV  = 4'd15;

  logic [0:0]       state;
  logic [0:0]       state_nxt;

  logic [WIDTH-1:0] out_q;
  logic             carry_q;
  logic             zero_q;
  logic             ovf_q;
  logic             valid_q;
  logic             cflag;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplr;
  logic [WIDTH-1:0] p_hi;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH:0]   adc_w;

  logic [WIDTH-1:0] alu_out_c;
  logic             alu_carry_c;
  logic             alu_ovf_c;
  logic             alu_cupd_c;

  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH-1:0] mul_hi_c;
  logic [WIDTH-1:0] mul_lo_c;

  logic             in_ready_c;
  logic             mul_start_c;
  logic             cap_c;
  logic [WIDTH-1:0] cap_out_c;
  logic             cap_carry_c;
  logic             cap_zero_c;
  logic             cap_ovf_c;
  logic             cap_cupd_c;

  assign a     = bus.A;
  assign b     = bus.B;
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} - {1'b0, b};
  assign adc_w = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cflag);

  // Single-cycle operation results
  always_comb begin
    alu_out_c   = '0;
    alu_carry_c = 1'b0;
    alu_ovf_c   = 1'b0;
    alu_cupd_c  = 1'b0;
    case (bus.ALU_Sel)
      OP_ADD: begin
        alu_out_c   = add_w[WIDTH-1:0];
        alu_carry_c = add_w[WIDTH];
        alu_ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
        alu_cupd_c  = 1'b1;
      end
      OP_SUB: begin
        alu_out_c   = sub_w[WIDTH-1:0];
        alu_carry_c = sub_w[WIDTH];
        alu_ovf_c   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
        alu_cupd_c  = 1'b1;
      end
      OP_AND:  alu_out_c = a & b;
      OP_OR:   alu_out_c = a | b;
      OP_XOR:  alu_out_c = a ^ b;
      OP_NOT:  alu_out_c = ~a;
      OP_SHL: begin
        alu_out_c   = {a[WIDTH-2:0], 1'b0};
        alu_carry_c = a[WIDTH-1];
        alu_cupd_c  = 1'b1;
      end
      OP_SHR: begin
        alu_out_c   = {1'b0, a[WIDTH-1:1]};
        alu_carry_c = a[0];
        alu_cupd_c  = 1'b1;
      end
      OP_ROL:  alu_out_c = {a[WIDTH-2:0], a[WIDTH-1]};
      OP_ROR:  alu_out_c = {a[0], a[WIDTH-1:1]};
      OP_SLT:  alu_out_c = WIDTH'($signed(a) < $signed(b));
      OP_SLTU: alu_out_c = WIDTH'(a < b);
      OP_ADC: begin
        alu_out_c   = adc_w[WIDTH-1:0];
        alu_carry_c = adc_w[WIDTH];
        alu_ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (adc_w[WIDTH-1] != a[WIDTH-1]);
        alu_cupd_c  = 1'b1;
      end
      OP_PASS: alu_out_c = b;
      default: ;
    endcase
  end

  // One shift-add step; on the last step this is also the final product
  assign mul_sum_c = {1'b0, p_hi} + ({1'b0, mcand} & {(WIDTH+1){mplr[0]}});
  assign mul_hi_c  = mul_sum_c[WIDTH:1];
  assign mul_lo_c  = {mul_sum_c[0], mplr[WIDTH-1:1]};

  assign in_ready_c = !rst && (state == S_IDLE) && (!valid_q || bus.out_ready);

  // Next-state and capture control
  always_comb begin
    state_nxt   = state;
    mul_start_c = 1'b0;
    cap_c       = 1'b0;
    cap_out_c   = '0;
    cap_carry_c = 1'b0;
    cap_zero_c  = 1'b0;
    cap_ovf_c   = 1'b0;
    cap_cupd_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.in_valid && in_ready_c) begin
          if (bus.ALU_Sel == OP_MUL) begin
            state_nxt   = S_MUL;
            mul_start_c = 1'b1;
          end else begin
            cap_c       = 1'b1;
            cap_out_c   = alu_out_c;
            cap_carry_c = alu_carry_c;
            cap_ovf_c   = alu_ovf_c;
            cap_zero_c  = (bus.ALU_Sel != OP_RSV) && (alu_out_c == '0);
            cap_cupd_c  = alu_cupd_c;
          end
        end
      end
      S_MUL: begin
        if (cnt == CNT_W'(WIDTH-1)) begin
          state_nxt   = S_IDLE;
          cap_c       = 1'b1;
          cap_out_c   = mul_lo_c;
          cap_carry_c = |mul_hi_c;
          cap_zero_c  = (mul_lo_c == '0);
          cap_cupd_c  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Result register: capture wins over a simultaneous drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      cflag   <= 1'b0;
    end else begin
      if (cap_c) begin
        out_q   <= cap_out_c;
        carry_q <= cap_carry_c;
        zero_q  <= cap_zero_c;
        ovf_q   <= cap_ovf_c;
        valid_q <= 1'b1;
        if (cap_cupd_c) cflag <= cap_carry_c;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mplr  <= '0;
      p_hi  <= '0;
      cnt   <= '0;
    end else if (mul_start_c) begin
      mcand <= a;
      mplr  <= b;
      p_hi  <= '0;
      cnt   <= '0;
    end else if (state == S_MUL) begin
      p_hi  <= mul_hi_c;
      mplr  <= mul_lo_c;
      cnt   <= cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = (state == S_MUL);
  assign bus.out_valid = valid_q;
  assign bus.ALU_Out   = out_q;
  assign bus.CarryOut  = carry_q;
  assign bus.Zero      = zero_q;
  assign bus.Overflow  = ovf_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: scoreboard of expected results plus
// hand-written sequences for multiply timing, backpressure and mid-multiply reset.
module tb_seq_alu;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_alu_if #(.WIDTH(WIDTH)) bus_if ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] out;
    logic       c, z, v;
    int         lat;
    int         acc;
  } exp_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] out;
    logic       c, z, v;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   popped   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Drive one request, wait for acceptance, optionally queue its expected result
  task automatic issue(input logic [3:0] sel, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eo, input logic ec, input logic ez, input logic ev,
                       input int lat, input bit push);
    int   n;
    exp_t e;
    @(negedge clk);
    bus_if.ALU_Sel  = sel;
    bus_if.A        = a;
    bus_if.B        = b;
    bus_if.in_valid = 1'b1;
    #1;
    n = 0;
    while (!bus_if.in_ready && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (!bus_if.in_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout sel=%0d in_ready=%0b exp=1", sel, bus_if.in_ready);
    end else if (push) begin
      e.out = eo; e.c = ec; e.z = ez; e.v = ev; e.lat = lat; e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  // Result monitor: one pop per handshake
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #2;
      if (!rst && bus_if.out_valid && bus_if.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result got=0x%0h exp=none", bus_if.ALU_Out);
        end else begin
          e = sb.pop_front();
          chk($sformatf("r%0d_out", popped), 32'(bus_if.ALU_Out), 32'(e.out));
          chk($sformatf("r%0d_carry", popped), 32'(bus_if.CarryOut), 32'(e.c));
          chk($sformatf("r%0d_zero", popped), 32'(bus_if.Zero), 32'(e.z));
          chk($sformatf("r%0d_ovf", popped), 32'(bus_if.Overflow), 32'(e.v));
          if (e.lat != 0) chk($sformatf("r%0d_latency", popped), 32'(cyc - e.acc), 32'(e.lat));
          popped++;
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    // A=0xB5 B=0x5A sweep: {sel, out, carry, zero, ovf}
    vecs[0]  = '{4'd0,  8'h0F, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{4'd1,  8'h5B, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{4'd2,  8'h10, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'd3,  8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{4'd4,  8'hEF, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'd5,  8'h4A, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd6,  8'h6A, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{4'd7,  8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{4'd8,  8'h6B, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'd9,  8'hDA, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'd10, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd11, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{4'd12, 8'hA2, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{4'd13, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{4'd14, 8'h5A, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{4'd15, 8'h00, 1'b0, 1'b0, 1'b0};

    bus_if.in_valid  = 1'b0;
    bus_if.A         = '0;
    bus_if.B         = '0;
    bus_if.ALU_Sel   = '0;
    bus_if.out_ready = 1'b1;
    rst = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("rst_busy", 32'(bus_if.busy), 32'd0);
    chk("rst_alu_out", 32'(bus_if.ALU_Out), 32'd0);
    chk("rst_carry", 32'(bus_if.CarryOut), 32'd0);
    chk("rst_zero", 32'(bus_if.Zero), 32'd0);
    chk("rst_ovf", 32'(bus_if.Overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Carry chain: ADC consumes the carry of the ADD accepted one cycle earlier
    issue(4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1, 1'b1);
    issue(4'd13, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    issue(4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1, 1'b1);
    issue(4'd1,  8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0, 1, 1'b1);
    issue(4'd10, 8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    issue(4'd11, 8'h80, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1'b1);

    // Multiply timing: busy for WIDTH cycles, result one cycle later
    issue(4'd12, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, 1'b0, 9, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk); #3;
      chk($sformatf("mul_busy_c%0d", k), 32'(bus_if.busy), 32'd1);
      chk($sformatf("mul_in_ready_c%0d", k), 32'(bus_if.in_ready), 32'd0);
      chk($sformatf("mul_out_valid_c%0d", k), 32'(bus_if.out_valid), 32'd0);
    end
    @(negedge clk); #3;
    chk("mul_done_busy", 32'(bus_if.busy), 32'd0);
    chk("mul_done_valid", 32'(bus_if.out_valid), 32'd1);
    issue(4'd12, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 9, 1'b1);
    wait_empty();

    // Backpressure: held result, stalled second request, drain+capture together
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    issue(4'd4, 8'hAA, 8'h0F, 8'hA5, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    fork
      issue(4'd14, 8'h00, 8'h33, 8'h33, 1'b0, 1'b0, 1'b0, 0, 1'b1);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk); #3;
          chk($sformatf("hold_out_%0d", k), 32'(bus_if.ALU_Out), 32'hA5);
          chk($sformatf("hold_valid_%0d", k), 32'(bus_if.out_valid), 32'd1);
          chk($sformatf("stall_in_ready_%0d", k), 32'(bus_if.in_ready), 32'd0);
        end
        @(negedge clk);
        bus_if.out_ready = 1'b1;
        @(negedge clk); #3;
        chk("second_out", 32'(bus_if.ALU_Out), 32'h33);
        chk("second_valid", 32'(bus_if.out_valid), 32'd1);
      end
    join
    wait_empty();

    // Reset during the multiply: set cflag first, then abandon the MUL
    issue(4'd6, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1, 1'b1);
    wait_empty();
    issue(4'd12, 8'h03, 8'h03, 8'h09, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    chk("pre_rst_busy", 32'(bus_if.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midmul_out_valid", 32'(bus_if.out_valid), 32'd0);
    chk("midmul_busy", 32'(bus_if.busy), 32'd0);
    chk("midmul_in_ready", 32'(bus_if.in_ready), 32'd0);
    chk("midmul_alu_out", 32'(bus_if.ALU_Out), 32'd0);
    chk("midmul_carry", 32'(bus_if.CarryOut), 32'd0);
    chk("midmul_zero", 32'(bus_if.Zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(4'd13, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1, 1'b1);
    wait_empty();

    // Full opcode sweep
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].sel, 8'hB5, 8'h5A, vecs[i].out, vecs[i].c, vecs[i].z, vecs[i].v,
            (vecs[i].sel == 4'd12) ? 9 : 1, 1'b1);
    end
    wait_empty();
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
